// File: rtl/conv_layer_sequencer_pkg.sv
// Shared instruction layout and opcodes for the layer controllers.
// Conv sequencer and top controller both decode through these helpers.
package conv_layer_sequencer_pkg;

  localparam int INSTR_BITS = 16;

  localparam int OPC_LSB  = 0;
  localparam int OPC_W    = 4;
  localparam int KSEL_LSB = 4;
  localparam int KSEL_W   = 2;
  localparam int OC_LSB   = 6;
  localparam int OC_W     = 4;
  localparam int IC_LSB   = 10;
  localparam int IC_W     = 3;
  localparam int ROW_LSB  = 13;
  localparam int ROW_W    = 3;

  typedef enum logic [OPC_W-1:0] {
    OP_CONV     = 4'b0001,
    OP_POOL     = 4'b0010,
    OP_CONCATE  = 4'b0011,
    OP_SHORTCUT = 4'b0100,
    OP_UPSAMPLE = 4'b0101,
    OP_END      = 4'b1111
  } opcode_e;

  typedef struct packed {
    logic [ROW_W-1:0]  row_m1;
    logic [IC_W-1:0]   ic_m1;
    logic [OC_W-1:0]   oc_m1;
    logic [KSEL_W-1:0] ksel;
  } conv_fields_t;

  function automatic logic [OPC_W-1:0] opcode_of(
    input logic [INSTR_BITS-1:0] ins
  );
    return ins[OPC_LSB +: OPC_W];
  endfunction

  function automatic logic is_conv(
    input logic [INSTR_BITS-1:0] ins
  );
    return opcode_of(ins) == OP_CONV;
  endfunction

  function automatic conv_fields_t decode_fields(
    input logic [INSTR_BITS-1:0] ins
  );
    conv_fields_t f;
    f.row_m1 = ins[ROW_LSB +: ROW_W];
    f.ic_m1  = ins[IC_LSB +: IC_W];
    f.oc_m1  = ins[OC_LSB +: OC_W];
    f.ksel   = ins[KSEL_LSB +: KSEL_W];
    return f;
  endfunction

endpackage

// File: rtl/conv_layer_sequencer_tile_index_counter.sv
// Three-level wrapping tile counter: ic innermost, then oc, then row.
// Limits are the latched *_m1 fields; last_o flags the final tile.
module tile_index_counter
  import conv_layer_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [ROW_W-1:0] row_m1_i,
  input  logic [OC_W-1:0]  oc_m1_i,
  input  logic [IC_W-1:0]  ic_m1_i,
  output logic [ROW_W-1:0] row_o,
  output logic [OC_W-1:0]  oc_o,
  output logic [IC_W-1:0]  ic_o,
  output logic             ic_first_o,
  output logic             ic_last_o,
  output logic             last_o
);

  logic [ROW_W-1:0] row_q, row_d;
  logic [OC_W-1:0]  oc_q, oc_d;
  logic [IC_W-1:0]  ic_q, ic_d;

  logic ic_wrap;
  logic oc_wrap;
  logic row_wrap;

  assign ic_wrap  = (ic_q == ic_m1_i);
  assign oc_wrap  = (oc_q == oc_m1_i);
  assign row_wrap = (row_q == row_m1_i);

  always_comb begin
    row_d = row_q;
    oc_d  = oc_q;
    ic_d  = ic_q;
    unique case (1'b1)
      clr_i: begin
        row_d = '0;
        oc_d  = '0;
        ic_d  = '0;
      end
      inc_i: begin
        if (!ic_wrap) begin
          ic_d = ic_q + 3'd1;
        end else begin
          ic_d = '0;
          if (!oc_wrap) begin
            oc_d = oc_q + 4'd1;
          end else begin
            oc_d  = '0;
            row_d = row_wrap ? '0 : row_q + 3'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      oc_q  <= '0;
      ic_q  <= '0;
    end else begin
      row_q <= row_d;
      oc_q  <= oc_d;
      ic_q  <= ic_d;
    end
  end

  assign row_o      = row_q;
  assign oc_o       = oc_q;
  assign ic_o       = ic_q;
  assign ic_first_o = (ic_q == '0);
  assign ic_last_o  = ic_wrap;
  assign last_o     = ic_wrap & oc_wrap & row_wrap;

endmodule

// File: rtl/conv_layer_sequencer.sv
// Conv layer sequencer: walks row/oc/ic tiles, one tile_start per tile,
// waits for tile_done, then pulses conv_fin once per layer.
module conv_layer_sequencer
  import conv_layer_sequencer_pkg::*;
#(
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic               conv_start,
  input  logic               tile_done,
  output logic               conv_fin,
  output logic               busy,
  output logic               tile_start,
  output logic [ROW_W-1:0]   row_idx,
  output logic [OC_W-1:0]    oc_idx,
  output logic [IC_W-1:0]    ic_idx,
  output logic               psum_clear,
  output logic               psum_last,
  output logic [KSEL_W-1:0]  kernel_sel
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e       state_q, state_d;
  conv_fields_t fld_q, fld_d;

  logic start_ok;
  logic cnt_clr;
  logic cnt_inc;
  logic cnt_last;
  logic ic_first;
  logic ic_last;

  assign start_ok = (state_q == S_IDLE) & conv_start & is_conv(instr);
  assign cnt_clr  = start_ok;
  assign cnt_inc  = (state_q == S_WAIT) & tile_done & ~cnt_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_ok) state_d = S_ISSUE;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (tile_done) state_d = cnt_last ? S_DONE : S_ISSUE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tile_start = 1'b0;
    psum_clear = 1'b0;
    psum_last  = 1'b0;
    conv_fin   = 1'b0;
    busy       = 1'b0;
    unique case (state_q)
      S_ISSUE: begin
        tile_start = 1'b1;
        psum_clear = ic_first;
        psum_last  = ic_last;
        busy       = 1'b1;
      end
      S_WAIT: busy = 1'b1;
      S_DONE: begin
        conv_fin = 1'b1;
        busy     = 1'b1;
      end
      default: ;
    endcase
  end

  // Fields only move on an accepted start, so they hold across the layer.
  always_comb begin
    fld_d = fld_q;
    if (start_ok) fld_d = decode_fields(instr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fld_q <= '0;
    end else begin
      fld_q <= fld_d;
    end
  end

  tile_index_counter u_idx (
    .clk        (clk),
    .rst_n      (reset),
    .clr_i      (cnt_clr),
    .inc_i      (cnt_inc),
    .row_m1_i   (fld_q.row_m1),
    .oc_m1_i    (fld_q.oc_m1),
    .ic_m1_i    (fld_q.ic_m1),
    .row_o      (row_idx),
    .oc_o       (oc_idx),
    .ic_o       (ic_idx),
    .ic_first_o (ic_first),
    .ic_last_o  (ic_last),
    .last_o     (cnt_last)
  );

  assign kernel_sel = fld_q.ksel;

endmodule
